// File: rtl/spram32_banked.sv
// rtl/spram32_banked.sv - banked 32-bit single-port RAM with request handshake and per-bank standby
module spram32_banked #(
  parameter int NBANK    = 2,
  parameter int IDLE_CYC = 64,
  parameter int WAKE_CYC = 3,
  localparam int AW      = 14 + $clog2(NBANK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [AW-1:0]     ai,
  input  logic [31:0]       vi,
  input  logic [3:0]        bmsk,
  output logic              rdy,
  output logic              rvalid,
  output logic [31:0]       vo,
  output logic [NBANK-1:0]  stdby
);

  localparam int SW  = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int ICW = $clog2(IDLE_CYC + 2);

  typedef enum logic [1:0] {ACTIVE, STDBY, WAKE} pstate_t;

  pstate_t        state   [NBANK];
  pstate_t        state_n [NBANK];
  logic [ICW-1:0] icnt    [NBANK];
  logic [ICW-1:0] icnt_n  [NBANK];
  logic [3:0]     wcnt    [NBANK];
  logic [3:0]     wcnt_n  [NBANK];
  logic [31:0]    dout    [NBANK];
  logic [NBANK-1:0] cs;
  logic [SW-1:0]  sel;
  logic [SW-1:0]  sel_q;
  logic [13:0]    addr;
  logic [3:0]     mwe_lo;
  logic [3:0]     mwe_hi;

  generate
    if (NBANK > 1) begin : g_sel
      assign sel = ai[AW-1:14];
    end else begin : g_sel1
      assign sel = '0;
    end
  endgenerate

  assign addr   = ai[13:0];
  assign mwe_lo = {bmsk[1], bmsk[1], bmsk[0], bmsk[0]};
  assign mwe_hi = {bmsk[3], bmsk[3], bmsk[2], bmsk[2]};

  // rst gates rdy so no macro sees CS during a reset cycle
  assign rdy = !rst && req && (state[sel] == ACTIVE);

  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      state_n[b] = state[b];
      icnt_n[b]  = icnt[b];
      wcnt_n[b]  = wcnt[b];
      cs[b]      = rdy && (sel == SW'(b));
      stdby[b]   = (state[b] == STDBY);
      case (state[b])
        ACTIVE: begin
          if (cs[b]) begin
            icnt_n[b] = '0;
          end else begin
            if (icnt[b] != ICW'(IDLE_CYC)) icnt_n[b] = icnt[b] + 1'b1;
            // enter standby on the edge where the count reaches IDLE_CYC
            if (IDLE_CYC != 0 && icnt_n[b] == ICW'(IDLE_CYC)) begin
              state_n[b] = STDBY;
              icnt_n[b]  = '0;
            end
          end
        end
        STDBY: begin
          icnt_n[b] = '0;
          if (!rst && req && sel == SW'(b)) begin
            state_n[b] = WAKE;
            wcnt_n[b]  = 4'(WAKE_CYC);
          end
        end
        WAKE: begin
          icnt_n[b] = '0;
          if (wcnt[b] <= 4'd1) begin
            state_n[b] = ACTIVE;
            wcnt_n[b]  = '0;
          end else begin
            wcnt_n[b] = wcnt[b] - 4'd1;
          end
        end
        default: begin
          state_n[b] = ACTIVE;
          icnt_n[b]  = '0;
          wcnt_n[b]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++) begin
        state[b] <= ACTIVE;
        icnt[b]  <= '0;
        wcnt[b]  <= '0;
      end
      rvalid <= 1'b0;
      sel_q  <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        state[b] <= state_n[b];
        icnt[b]  <= icnt_n[b];
        wcnt[b]  <= wcnt_n[b];
      end
      rvalid <= rdy && !we;
      if (rdy && !we) sel_q <= sel;
    end
  end

  // Each bank is a low/high pair of 16K x 16 macros with nibble write masks
  generate
    for (genvar g = 0; g < NBANK; g++) begin : g_bank
      logic [15:0] mem_lo [16384];
      logic [15:0] mem_hi [16384];
      logic [31:0] do_q;

      always_ff @(posedge clk) begin
        if (cs[g] && we) begin
          for (int n = 0; n < 4; n++) begin
            if (mwe_lo[n]) mem_lo[addr][4*n +: 4] <= vi[4*n +: 4];
            if (mwe_hi[n]) mem_hi[addr][4*n +: 4] <= vi[16 + 4*n +: 4];
          end
        end
        if (cs[g] && !we) do_q <= {mem_hi[addr], mem_lo[addr]};
      end

      assign dout[g] = do_q;
    end
  endgenerate

  assign vo = rvalid ? dout[sel_q] : 32'h0;

endmodule

// File: doc/spram32_banked.md
# spram32_banked

Parametrised 32-bit single-port RAM built from NBANK pairs of SP256K 16K×16 macros, giving NBANK×16K words. It sits between the eForth core's memory bus and the SPRAM macros. It adds a valid/ready request handshake, a bank-select pipeline so the read mux follows the registered macro output, and per-bank idle power-down (STDBY) with a timed wake-up.

## Interface
- NBANK, default 2: number of 16K×32 banks (each bank is two SP256K macros). Legal values are 1, 2 and 4.
- IDLE_CYC, default 64: number of consecutive unaccessed cycles before a bank enters standby. A value of 0 disables power-down.
- WAKE_CYC, default 3: number of cycles a bank spends in WAKE before it can be accessed. Legal range is 1..15.
- AW, derived: 14 + clog2(NBANK). Not overridable.

Ports:
- clk  in  1  — system clock; all logic is rising-edge.
- rst  in  1  — synchronous, active-high reset.
- req  in  1  — access request; must be held until rdy.
- we  in  1  — 1 = write, 0 = read; held with req.
- ai  in  AW  — word address; held with req.
- vi  in  32  — write data.
- bmsk  in  4  — byte write enables; bit n enables byte n.
- rdy  out  1  — request accepted this cycle.
- rvalid  out  1  — vo carries read data this cycle.
- vo  out  32  — read data.
- stdby  out  NBANK  — per-bank standby status; drives the macro STDBY pins.

## Operation
- Bank index `sel = ai[AW-1:14]` (0 when NBANK = 1). Macro address is `ai[13:0]`.
- Low macro of each bank gets vi[15:0] with MASKWE {bmsk[1],bmsk[1],bmsk[0],bmsk[0]}. High macro gets vi[31:16] with MASKWE {bmsk[3],bmsk[3],bmsk[2],bmsk[2]}.
- Per-bank state machine, reset to ACTIVE:
  - ACTIVE → STDBY when the idle counter reaches IDLE_CYC (only if IDLE_CYC ≠ 0).
  - STDBY → WAKE when req=1 and sel equals this bank.
  - WAKE → ACTIVE after WAKE_CYC cycles in WAKE (wake counter loaded on entry).
- Idle counter, one per bank:
  - Cleared to 0 on reset, on any accepted access to that bank, and while the bank is not ACTIVE.
  - Otherwise increments, saturating at IDLE_CYC.
  - Banks count independently, including while a request is stalled on another bank.
- stdby[b] = 1 only in STDBY. SLEEP is tied 0 and PWROFF_N is tied 1.
- rdy = req && state[sel] == ACTIVE. This is combinational from registered state; there is no combinational path from rdy back into req.
- On an accepting cycle, CS is asserted only to bank sel and WE = we. All other banks have CS=0.
- Write: data is committed at the accepting edge; rvalid stays 0.
- Read: sel_q <= sel and rvalid <= 1 at the accepting edge.
  - vo = rvalid ? DO[sel_q] : 32'h0.
  - Read mux uses the registered sel_q, never the live ai.
- req dropped while a bank is in WAKE: the wake completes and the bank becomes ACTIVE with its idle counter at 0.
- ai, we, vi or bmsk changing while req=1 && rdy=0 is a protocol violation; behaviour is unspecified except that no write occurs until rdy.
- One access per cycle at most; back-to-back accepts on consecutive cycles are legal.

## Timing
- Reset values: rdy=0 (req gated by reset cycle), rvalid=0, vo=0, stdby=0, all banks ACTIVE, counters 0, sel_q=0.
- Read latency, bank ACTIVE: accept at cycle t → rvalid=1 and vo valid at cycle t+1. Throughput is 1 per cycle.
- Read-after-write to the same address on consecutive accepts returns the new data.
- Access to a STDBY bank:
  - req seen at cycle t, rdy=0.
  - WAKE occupies cycles t+1 .. t+WAKE_CYC; stdby[b] falls at t+1.
  - ACTIVE and rdy=1 at cycle t+WAKE_CYC+1.
  - Total stall is WAKE_CYC+1 cycles.
- Idle entry: last accept to bank b at cycle t → stdby[b]=1 from cycle t+IDLE_CYC+1.
- Reset asserted mid-WAKE or mid-read: the next cycle shows the reset values. No write is issued during the rst cycle; CS and WE are forced 0.

## Test plan
Bench configuration: NBANK=4, IDLE_CYC=8, WAKE_CYC=3.
- Reset: hold rst 2 cycles with req=1 → rdy=0, rvalid=0, vo=0, stdby=4'b0000.
- Byte-masked write then read:
  - Write 0xDEADBEEF to 0x0123 with bmsk=4'hF.
  - Write 0x11223344 to 0x0123 with bmsk=4'b0101.
  - Read 0x0123 → vo=0xDE22BE44 one cycle after accept.
- Bank isolation and mux:
  - Write 0xA0000000+b to address b×0x4000 for b=0..3.
  - Back-to-back reads b=3,0,2,1 → rvalid=1 for 4 consecutive cycles with vo = 0xA0000003, 0xA0000000, 0xA0000002, 0xA0000001.
- Idle and wake:
  - After the last accept to bank 2, idle 8 cycles → stdby[2]=1 at accept+9.
  - Read bank 2 → rdy low 4 cycles, then high; rvalid follows 1 cycle later with the stored data.
- Independent idling: keep accessing bank 0 every cycle for 20 cycles → stdby=4'b1110, stdby[0] never set.
- Reset during wake: assert rst in cycle 2 of WAKE → all banks ACTIVE, stdby=0, no spurious rvalid, memory contents unchanged.
